decode: RTL and testbench



---
 rtl/decode.sv | 274 +++++++++++++++++++++++++++
 tb/tb_decode.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode.sv
// Decode stage: splits fetched instructions into fields, tracks pending register writes, and stalls on RAW hazards.
// Latency: an instruction accepted from fetch in cycle N is presented on the issue port in cycle N+1.
// Backpressure: the fetch_keep handshake holds fetch while the issue slot is full and not taken, or while a source register is pending.
//
// Ports:
//   clk, arstn            - clock, asynchronous active-low reset
//   fetch_inst_i/id_i     - instruction and PC offered by fetch (valid in the same cycle)
//   fetch_state_o         - fetch_next consumes the offered instruction, fetch_keep holds it
//   issue_*               - valid/ready issue register towards execute (op, rd, rs1, rs2, imm, pc)
//   wb_valid_i/wb_rd_i    - writeback retiring a register write (clears its scoreboard bit)
//   halted_o              - HALT accepted; fetch is frozen until reset

package decode_pkg;

    typedef logic [31:0] instruction_t;
    typedef logic [31:0] pc_t;

    typedef enum logic {
        fetch_keep = 1'b0,
        fetch_next = 1'b1
    } fetch_state_t;

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_ADD     = 3'd1,
        OP_SUB     = 3'd2,
        OP_ADDI    = 3'd3,
        OP_LOAD    = 3'd4,
        OP_STORE   = 3'd5,
        OP_HALT    = 3'd6,
        OP_ILLEGAL = 3'd7
    } issue_op_t;

endpackage

module decode
    import decode_pkg::*;
#(
    parameter int REG_NUM   = 32,
    parameter int IMM_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 arstn,

    input  instruction_t         fetch_inst_i,
    input  pc_t                  fetch_id_i,
    output fetch_state_t         fetch_state_o,

    output logic                 issue_valid_o,
    input  logic                 issue_ready_i,
    output logic [2:0]           issue_op_o,
    output logic [4:0]           issue_rd_o,
    output logic [4:0]           issue_rs1_o,
    output logic [4:0]           issue_rs2_o,
    output logic [IMM_WIDTH-1:0] issue_imm_o,
    output pc_t                  issue_pc_o,

    input  logic                 wb_valid_i,
    input  logic [4:0]           wb_rd_i,

    output logic                 halted_o
);

    // ------------------------------------------------------------------
    // Types
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    typedef struct packed {
        issue_op_t            op;
        logic [4:0]           rd;
        logic [4:0]           rs1;
        logic [4:0]           rs2;
        logic [IMM_WIDTH-1:0] imm;
        pc_t                  pc;
    } slot_t;

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    state_t               state_q;
    state_t               state_d;

    slot_t                slot_q;
    logic                 slot_vld_q;

    logic [REG_NUM-1:0]   sb_q;
    logic [REG_NUM-1:0]   sb_d;

    slot_t                dec;
    logic                 dec_reads_rs1;
    logic                 dec_reads_rs2;
    logic                 dec_writes_rd;
    logic                 hazard;
    logic                 slot_free;
    logic                 accept;

    // ------------------------------------------------------------------
    // Instruction field decode
    // ------------------------------------------------------------------
    always_comb begin
        dec           = '0;
        dec_reads_rs1 = 1'b0;
        dec_reads_rs2 = 1'b0;
        dec_writes_rd = 1'b0;

        dec.rd  = fetch_inst_i[25:21];
        dec.rs1 = fetch_inst_i[20:16];
        dec.rs2 = fetch_inst_i[15:11];
        dec.imm = {{(IMM_WIDTH-16){fetch_inst_i[15]}}, fetch_inst_i[15:0]};
        dec.pc  = fetch_id_i;

        unique case (fetch_inst_i[31:26])
            6'h00: dec.op = OP_NOP;
            6'h01: begin
                dec.op        = OP_ADD;
                dec_reads_rs1 = 1'b1;
                dec_reads_rs2 = 1'b1;
                dec_writes_rd = 1'b1;
            end
            6'h02: begin
                dec.op        = OP_SUB;
                dec_reads_rs1 = 1'b1;
                dec_reads_rs2 = 1'b1;
                dec_writes_rd = 1'b1;
            end
            6'h03: begin
                dec.op        = OP_ADDI;
                dec_reads_rs1 = 1'b1;
                dec_writes_rd = 1'b1;
            end
            6'h04: begin
                dec.op        = OP_LOAD;
                dec_reads_rs1 = 1'b1;
                dec_writes_rd = 1'b1;
            end
            6'h05: begin
                dec.op        = OP_STORE;
                dec_reads_rs1 = 1'b1;
                dec_reads_rs2 = 1'b1;
            end
            6'h3F: dec.op = OP_HALT;
            default: begin
                // Illegal encodings carry no register meaning downstream.
                dec.op  = OP_ILLEGAL;
                dec.rd  = 5'd0;
                dec.rs1 = 5'd0;
                dec.rs2 = 5'd0;
            end
        endcase
    end

    // Registered scoreboard only: a writeback in this cycle is not bypassed,
    // which keeps fetch_state_o independent of wb_* in the same cycle.
    always_comb begin
        hazard = 1'b0;
        if (dec_reads_rs1 && (dec.rs1 != 5'd0) && sb_q[dec.rs1]) begin
            hazard = 1'b1;
        end
        if (dec_reads_rs2 && (dec.rs2 != 5'd0) && sb_q[dec.rs2]) begin
            hazard = 1'b1;
        end
    end

    // Slot can take a new entry if empty or if it is being handed over now.
    assign slot_free = !slot_vld_q || issue_ready_i;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q <= ST_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_WAIT: state_d = ST_RUN;   // one settle cycle for the instruction ROM
            ST_RUN: begin
                if (accept && (dec.op == OP_HALT)) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_WAIT;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        accept        = 1'b0;
        fetch_state_o = fetch_keep;
        halted_o      = 1'b0;
        unique case (state_q)
            ST_WAIT: begin
                accept        = 1'b0;
                fetch_state_o = fetch_keep;
            end
            ST_RUN: begin
                accept        = slot_free && !hazard;
                fetch_state_o = accept ? fetch_next : fetch_keep;
            end
            ST_HALT: begin
                halted_o      = 1'b1;
                fetch_state_o = fetch_keep;
            end
            default: begin
                accept        = 1'b0;
                fetch_state_o = fetch_keep;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Issue slot
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            slot_q     <= '0;
            slot_vld_q <= 1'b0;
        end else if (accept) begin
            slot_q     <= dec;
            slot_vld_q <= 1'b1;
        end else if (slot_vld_q && issue_ready_i) begin
            // Drain only; fields are left as-is since valid is low.
            slot_vld_q <= 1'b0;
        end
    end

    assign issue_valid_o = slot_vld_q;
    assign issue_op_o    = slot_q.op;
    assign issue_rd_o    = slot_q.rd;
    assign issue_rs1_o   = slot_q.rs1;
    assign issue_rs2_o   = slot_q.rs2;
    assign issue_imm_o   = slot_q.imm;
    assign issue_pc_o    = slot_q.pc;

    // ------------------------------------------------------------------
    // Scoreboard of pending register writes
    // ------------------------------------------------------------------
    always_comb begin
        sb_d = sb_q;
        if (wb_valid_i) begin
            sb_d[wb_rd_i] = 1'b0;
        end
        // Set after clear so a same-cycle set on the same register wins.
        if (accept && dec_writes_rd && (dec.rd != 5'd0)) begin
            sb_d[dec.rd] = 1'b1;
        end
        sb_d[0] = 1'b0;   // r0 is never tracked
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

endmodule

// File: tb/tb_decode.sv
// Directed testbench for decode: acts as the fetch ROM and writeback source.
// Inputs change 1 ns after the rising edge; outputs are checked on the falling edge.
// Summary line reports total checks and errors.

module tb_decode;
    import decode_pkg::*;

    logic           clk;
    logic           arstn;
    instruction_t   fetch_inst_i;
    pc_t            fetch_id_i;
    fetch_state_t   fetch_state_o;
    logic           issue_valid_o;
    logic           issue_ready_i;
    logic [2:0]     issue_op_o;
    logic [4:0]     issue_rd_o;
    logic [4:0]     issue_rs1_o;
    logic [4:0]     issue_rs2_o;
    logic [31:0]    issue_imm_o;
    pc_t            issue_pc_o;
    logic           wb_valid_i;
    logic [4:0]     wb_rd_i;
    logic           halted_o;

    int             checks;
    int             errors;
    int             pc;
    logic [31:0]    rom [0:15];

    localparam logic [31:0] KEEP = 32'd0;
    localparam logic [31:0] NEXT = 32'd1;

    decode #(.REG_NUM(32), .IMM_WIDTH(32)) dut (
        .clk           (clk),
        .arstn         (arstn),
        .fetch_inst_i  (fetch_inst_i),
        .fetch_id_i    (fetch_id_i),
        .fetch_state_o (fetch_state_o),
        .issue_valid_o (issue_valid_o),
        .issue_ready_i (issue_ready_i),
        .issue_op_o    (issue_op_o),
        .issue_rd_o    (issue_rd_o),
        .issue_rs1_o   (issue_rs1_o),
        .issue_rs2_o   (issue_rs2_o),
        .issue_imm_o   (issue_imm_o),
        .issue_pc_o    (issue_pc_o),
        .wb_valid_i    (wb_valid_i),
        .wb_rd_i       (wb_rd_i),
        .halted_o      (halted_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [15:0] lo);
        return {op, rd, rs1, lo};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fetch();
        fetch_id_i   = pc;
        fetch_inst_i = rom[pc[3:0]];
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 32'd0;
    endtask

    // One clock: fetch advances if decode asserted fetch_next before the edge.
    task automatic cycle();
        logic took;
        took = (fetch_state_o == fetch_next);
        @(posedge clk);
        #1;
        if (took) pc++;
        wb_valid_i = 1'b0;
        drive_fetch();
        #4;
    endtask

    // Asserts reset, holds it for two edges, releases it on a falling edge.
    task automatic do_reset();
        arstn      = 1'b0;
        pc         = 0;
        wb_valid_i = 1'b0;
        drive_fetch();
        repeat (2) @(posedge clk);
        #5;
        arstn = 1'b1;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        pc            = 0;
        arstn         = 1'b0;
        issue_ready_i = 1'b1;
        wb_valid_i    = 1'b0;
        wb_rd_i       = 5'd0;
        clear_rom();

        // ---------------- Reset then stream ----------------
        rom[0] = enc(6'h03, 5'd1, 5'd0, 16'd5);     // ADDI r1,r0,5
        rom[1] = enc(6'h01, 5'd2, 5'd0, 16'd0);     // ADD  r2,r0,r0
        drive_fetch();
        #1;
        chk("rst_fetch_state", 32'(fetch_state_o), KEEP);
        chk("rst_valid",       32'(issue_valid_o), 32'd0);
        chk("rst_halted",      32'(halted_o),      32'd0);
        chk("rst_op",          32'(issue_op_o),    32'd0);
        chk("rst_rd",          32'(issue_rd_o),    32'd0);
        chk("rst_imm",         issue_imm_o,        32'd0);
        chk("rst_pc",          issue_pc_o,         32'd0);
        do_reset();
        chk("s1_wait_keep", 32'(fetch_state_o), KEEP);
        cycle();
        chk("s1_next0", 32'(fetch_state_o), NEXT);
        chk("s1_valid_empty", 32'(issue_valid_o), 32'd0);
        cycle();
        chk("s1_addi_valid", 32'(issue_valid_o), 32'd1);
        chk("s1_addi_op",    32'(issue_op_o),    32'd3);
        chk("s1_addi_imm",   issue_imm_o,        32'd5);
        chk("s1_addi_pc",    issue_pc_o,         32'd0);
        chk("s1_addi_rd",    32'(issue_rd_o),    32'd1);
        chk("s1_next1",      32'(fetch_state_o), NEXT);
        cycle();
        chk("s1_add_valid", 32'(issue_valid_o), 32'd1);
        chk("s1_add_op",    32'(issue_op_o),    32'd1);
        chk("s1_add_pc",    issue_pc_o,         32'd1);
        chk("s1_add_rd",    32'(issue_rd_o),    32'd2);

        // ---------------- RAW hazard ----------------
        clear_rom();
        rom[0] = enc(6'h03, 5'd3, 5'd0, 16'd1);             // ADDI r3,r0,1
        rom[1] = enc(6'h01, 5'd4, 5'd3, {5'd3, 11'd0});     // ADD  r4,r3,r3
        do_reset();
        chk("s2_wait_keep", 32'(fetch_state_o), KEEP);
        cycle();
        chk("s2_next0", 32'(fetch_state_o), NEXT);
        cycle();
        chk("s2_haz_keep0", 32'(fetch_state_o), KEEP);
        chk("s2_addi_op",   32'(issue_op_o),    32'd3);
        cycle();
        chk("s2_haz_keep1", 32'(fetch_state_o), KEEP);
        chk("s2_drained",   32'(issue_valid_o), 32'd0);
        wb_valid_i = 1'b1;
        wb_rd_i    = 5'd3;
        #1;
        chk("s2_wb_no_bypass", 32'(fetch_state_o), KEEP);
        #3;
        cycle();
        chk("s2_next_after_wb", 32'(fetch_state_o), NEXT);
        cycle();
        chk("s2_add_valid", 32'(issue_valid_o), 32'd1);
        chk("s2_add_op",    32'(issue_op_o),    32'd1);
        chk("s2_add_rs1",   32'(issue_rs1_o),   32'd3);
        chk("s2_add_rs2",   32'(issue_rs2_o),   32'd3);
        chk("s2_add_rd",    32'(issue_rd_o),    32'd4);
        chk("s2_add_pc",    issue_pc_o,         32'd1);

        // ---------------- Backpressure ----------------
        clear_rom();
        rom[0] = enc(6'h03, 5'd1, 5'd0, 16'd7);     // ADDI r1,r0,7
        rom[1] = enc(6'h03, 5'd2, 5'd0, 16'd9);     // ADDI r2,r0,9
        issue_ready_i = 1'b0;
        do_reset();
        cycle();
        chk("s3_next0", 32'(fetch_state_o), NEXT);
        cycle();
        for (int i = 0; i < 4; i++) begin
            chk("s3_bp_keep",  32'(fetch_state_o), KEEP);
            chk("s3_bp_valid", 32'(issue_valid_o), 32'd1);
            chk("s3_bp_op",    32'(issue_op_o),    32'd3);
            chk("s3_bp_imm",   issue_imm_o,        32'd7);
            chk("s3_bp_rd",    32'(issue_rd_o),    32'd1);
            chk("s3_bp_pc",    issue_pc_o,         32'd0);
            cycle();
        end
        issue_ready_i = 1'b1;
        #1;
        chk("s3_ready_next", 32'(fetch_state_o), NEXT);
        chk("s3_ready_imm",  issue_imm_o,        32'd7);
        #3;
        cycle();
        chk("s3_second_valid", 32'(issue_valid_o), 32'd1);
        chk("s3_second_imm",   issue_imm_o,        32'd9);
        chk("s3_second_rd",    32'(issue_rd_o),    32'd2);
        chk("s3_second_pc",    issue_pc_o,         32'd1);

        // ---------------- HALT ----------------
        clear_rom();
        rom[2] = enc(6'h3F, 5'd0, 5'd0, 16'd0);     // HALT
        rom[3] = enc(6'h01, 5'd5, 5'd0, 16'd0);     // ADD r5,r0,r0 (must not be taken)
        do_reset();
        cycle();
        cycle();
        cycle();
        chk("s4_pre_halted", 32'(halted_o),      32'd0);
        chk("s4_halt_next",  32'(fetch_state_o), NEXT);
        cycle();
        chk("s4_halted",    32'(halted_o),      32'd1);
        chk("s4_keep",      32'(fetch_state_o), KEEP);
        chk("s4_halt_op",   32'(issue_op_o),    32'd6);
        chk("s4_halt_pc",   issue_pc_o,         32'd2);
        chk("s4_halt_vld",  32'(issue_valid_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("s4_frozen_keep",   32'(fetch_state_o), KEEP);
            chk("s4_frozen_halted", 32'(halted_o),      32'd1);
        end
        chk("s4_drained",  32'(issue_valid_o), 32'd0);
        chk("s4_fetch_id", fetch_id_i,         32'd3);

        // ---------------- Immediate and illegal ----------------
        clear_rom();
        rom[0] = enc(6'h03, 5'd6, 5'd0, 16'hFFFF);            // ADDI r6,r0,-1
        rom[1] = enc(6'h2A, 5'd5, 5'd7, 16'hFFFF);            // illegal, raw rd=5
        rom[2] = enc(6'h01, 5'd8, 5'd5, {5'd5, 11'd0});       // ADD r8,r5,r5
        do_reset();
        cycle();
        cycle();
        chk("s5_imm_op",  32'(issue_op_o), 32'd3);
        chk("s5_imm_ext", issue_imm_o,     32'hFFFF_FFFF);
        chk("s5_next_ill", 32'(fetch_state_o), NEXT);
        cycle();
        chk("s5_ill_op",  32'(issue_op_o),  32'd7);
        chk("s5_ill_rd",  32'(issue_rd_o),  32'd0);
        chk("s5_ill_rs1", 32'(issue_rs1_o), 32'd0);
        chk("s5_ill_rs2", 32'(issue_rs2_o), 32'd0);
        chk("s5_ill_no_sb", 32'(fetch_state_o), NEXT);
        cycle();
        chk("s5_add_op",  32'(issue_op_o),  32'd1);
        chk("s5_add_rs1", 32'(issue_rs1_o), 32'd5);
        chk("s5_add_pc",  issue_pc_o,       32'd2);

        // ---------------- Mid-stream reset ----------------
        clear_rom();
        rom[0] = enc(6'h03, 5'd9, 5'd0, 16'd3);               // ADDI r9,r0,3
        rom[1] = enc(6'h01, 5'd10, 5'd9, {5'd9, 11'd0});      // ADD r10,r9,r9
        do_reset();
        cycle();
        cycle();
        chk("s6_full",      32'(issue_valid_o), 32'd1);
        chk("s6_haz_keep",  32'(fetch_state_o), KEEP);
        arstn  = 1'b0;
        pc     = 0;
        rom[0] = enc(6'h01, 5'd10, 5'd9, {5'd9, 11'd0});      // ADD r10,r9,r9 first after reset
        drive_fetch();
        #1;
        chk("s6_rst_valid", 32'(issue_valid_o), 32'd0);
        chk("s6_rst_op",    32'(issue_op_o),    32'd0);
        chk("s6_rst_keep",  32'(fetch_state_o), KEEP);
        do_reset();
        chk("s6_wait_keep", 32'(fetch_state_o), KEEP);
        cycle();
        chk("s6_sb_cleared", 32'(fetch_state_o), NEXT);
        cycle();
        chk("s6_add_valid", 32'(issue_valid_o), 32'd1);
        chk("s6_add_op",    32'(issue_op_o),    32'd1);
        chk("s6_add_rs1",   32'(issue_rs1_o),   32'd9);
        chk("s6_add_pc",    issue_pc_o,         32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
